// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// default reset PC, default sequential step and a word-alignment helper.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_STALL    = 2'd2,
        ST_REDIRECT = 2'd3
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT  = 4;

    // Rebuild a byte address from a word address (low two bits forced to zero).
    function automatic logic [31:0] word_align(input logic [29:0] word_addr);
        return {word_addr, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: an accepted taken branch wins, otherwise an accepted
// fetch advances by PC_STEP (wrapping modulo 2^32), otherwise the PC holds.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic        br_take,
    input  logic [29:0] br_word,
    input  logic        fire,
    output logic [31:0] next_pc
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    // Priority select of the next program counter value.
    always_comb begin
        // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
        next_pc = pc;
        if (br_take) begin
            next_pc = word_align(br_word);
        end else if (fire) begin
            next_pc = pc + STEP;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch program-counter sequencer. A four-state FSM decides
// when a fetch may be requested; the PC advances on accepted fetches and is
// redirected by taken branches, which spend one cycle in REDIRECT.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic        fetch_fire,
    output logic        redirect,
    output logic        err_misalign,
    output logic [15:0] fetch_cnt
);

    pc_state_e   state;
    logic        br_take;
    logic [31:0] next_pc;

    // Branches are only honoured once the sequencer has left IDLE.
    assign br_take    = br_valid & br_taken & (state != ST_IDLE);
    assign imem_req   = (state == ST_FETCH) & ~stall;
    assign fetch_fire = imem_req & imem_ready;
    assign imem_addr  = pc;

    pc_next_mux #(
        .PC_STEP (PC_STEP)
    ) u_next_mux (
        .pc      (pc),
        .br_take (br_take),
        .br_word (br_target[31:2]),
        .fire    (fetch_fire),
        .next_pc (next_pc)
    );

    // Sequencer FSM with registered redirect flag; a taken branch overrides stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            redirect <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            redirect <= 1'b0;
            if (br_take) begin
                state    <= ST_REDIRECT;
                redirect <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE:     state <= ST_FETCH;
                    ST_FETCH:    if (stall) state <= ST_STALL;
                    ST_STALL:    if (!stall) state <= ST_FETCH;
                    ST_REDIRECT: state <= stall ? ST_STALL : ST_FETCH;
                    default:     state <= ST_IDLE;
                endcase
            end
        end
    end

    // Program counter register; reset discards any pending branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Accepted-fetch counter (free-running wrap) and sticky misalignment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt    <= 16'h0000;
            err_misalign <= 1'b0;
        end else begin
            if (fetch_fire) begin
                fetch_cnt <= fetch_cnt + 16'h0001;
            end
            if (br_take && (br_target[1:0] != 2'b00)) begin
                err_misalign <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 4, meaning sequential byte increment per fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hold PC and suppress fetch request.
REQ-006 SHALL have port br_valid  input  1  branch resolution present this cycle.
REQ-007 SHALL have port br_taken  input  1  branch taken; qualified by br_valid.
REQ-008 SHALL have port br_target  input  32  branch target address (inA + inB*4 from the upstream target adder).
REQ-009 SHALL have port imem_ready  input  1  instruction memory accepts request this cycle.
REQ-010 SHALL have port imem_req  output  1  fetch request.
REQ-011 SHALL have port imem_addr  output  32  fetch address; equals pc.
REQ-012 SHALL have port pc  output  32  current program counter.
REQ-013 SHALL have port fetch_fire  output  1  imem_req & imem_ready; one accepted fetch.
REQ-014 SHALL have port redirect  output  1  high for exactly the one cycle spent in REDIRECT.
REQ-015 SHALL have port err_misalign  output  1  sticky; taken branch with br_target[1:0] != 2'b00.
REQ-016 SHALL have port fetch_cnt  output  16  count of accepted fetches, wraps 16'hFFFF -> 0.

Function
REQ-017 SHALL implement states IDLE, FETCH, STALL, REDIRECT.
REQ-018 SHALL go IDLE -> FETCH on the first clock edge after reset release, unconditionally.
REQ-019 SHALL drive imem_req = (state==FETCH) & ~stall, combinationally; imem_req SHALL be 0 in IDLE, STALL, REDIRECT.
REQ-020 SHALL, on fetch_fire with no taken branch, load pc <= pc + PC_STEP modulo 2^32 (32'hFFFF_FFFC + 4 -> 0) and increment fetch_cnt.
REQ-021 SHALL move FETCH -> STALL when stall=1; STALL -> FETCH on first cycle with stall=0; pc held throughout.
REQ-022 SHALL, when br_valid & br_taken in FETCH, STALL or REDIRECT, load pc <= {br_target[31:2],2'b00} and enter REDIRECT next cycle.
REQ-023 SHALL give taken branch priority over stall and over sequential increment in the same cycle; a fetch_fire in that cycle still counts in fetch_cnt.
REQ-024 SHALL ignore br_valid & br_taken while in IDLE; br_valid with br_taken=0 SHALL have no effect.
REQ-025 SHALL leave REDIRECT after one cycle to FETCH, or to STALL if stall=1 that cycle.
REQ-026 SHALL set err_misalign on any accepted taken branch with br_target[1:0] != 0; cleared only by reset.
REQ-027 SHALL keep imem_addr equal to pc in every state.

Reset
REQ-028 SHALL on rst_n=0, immediately and regardless of clk: pc=RESET_PC, state=IDLE, fetch_cnt=0, err_misalign=0, redirect=0; imem_req=0 and fetch_fire=0 follow.
REQ-029 SHALL, on reset asserted mid-fetch or mid-REDIRECT, discard the pending branch and restart from RESET_PC.

Structure
REQ-030 SHALL place the state enumeration, PC_STEP default and RESET_PC default in shared package pc_pkg.
REQ-031 SHALL instantiate one sub-module, pc_next_mux, computing next pc from pc, PC_STEP, branch and fire inputs; FSM and counters stay in pc_sequencer.

Verification
REQ-032 SHALL cover: release reset, imem_ready=1 for 3 cycles -> imem_addr 0, 4, 8; fetch_cnt=3.
REQ-033 SHALL cover: pc=0x10, br_valid=br_taken=1, br_target=0x100 -> redirect=1 next cycle, imem_req=0; following cycle imem_addr=0x100.
REQ-034 SHALL cover: stall=1 for 4 cycles at pc=0x20 with imem_ready=1 -> imem_req=0, pc stays 0x20, fetch_cnt unchanged.
REQ-035 SHALL cover: stall=1 and taken branch to 0x40 in same cycle -> pc=0x40, REDIRECT, then STALL until stall=0.
REQ-036 SHALL cover: br_target=0x102 taken -> pc=0x100, err_misalign=1 held until rst_n=0.
REQ-037 SHALL cover: pc=0xFFFF_FFFC fire -> pc=0; 65536 fires -> fetch_cnt wraps to 0; rst_n pulsed mid-REDIRECT -> pc=RESET_PC, state IDLE.
